// File: rtl/out_port_serializer.sv
// Purpose: queues 4-bit ALU output values and sends each one LSB-first as an async serial frame (start, 4 data, [parity], stop); OUT_SER_PARITY_EN adds an even parity bit.
// Latency: a push into an idle, empty block starts its frame one edge later; a frame lasts 6*BAUD_DIV cycles (7*BAUD_DIV with parity) and queued frames follow back-to-back.
// Backpressure: none toward the CPU; a push while FULL without a same-edge pop is dropped and sets sticky OVF.
module out_port_serializer #(
    parameter int DEPTH    = 4,
    parameter int BAUD_DIV = 4
) (
    input  logic       CK,
    input  logic       RST_N,
    input  logic       LD_OUT,
    input  logic [3:0] BUS,
    output logic       TXD,
    output logic       BUSY,
    output logic       FULL,
    output logic [4:0] COUNT,
    output logic       OVF
);
    localparam int PW = $clog2(DEPTH);
    localparam logic [7:0] TMAX = 8'(BAUD_DIV - 1);

`ifdef OUT_SER_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

    logic [3:0]    mem [DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [4:0]    count_q;
    logic          ovf_q;
    state_t        state_q, state_d;
    logic [7:0]    timer_q, timer_d;
    logic [1:0]    bit_q, bit_d;
    logic [3:0]    shift_q, shift_d;
    logic          txd_q, txd_d;
    logic          pop, push, full, tick;
`ifdef OUT_SER_PARITY_EN
    logic          par_q, par_d;
`endif

    assign full = (count_q == 5'(DEPTH));
    assign tick = (timer_q == 8'd0);
    // A pop on the same edge frees a slot, so a push while full is still accepted.
    assign push = LD_OUT && (!full || pop);

    always_comb begin
        state_d = state_q;
        timer_d = tick ? timer_q : timer_q - 8'd1;
        bit_d   = bit_q;
        shift_d = shift_q;
        txd_d   = txd_q;
        pop     = 1'b0;
`ifdef OUT_SER_PARITY_EN
        par_d   = par_q;
`endif
        case (state_q)
            IDLE: begin
                txd_d = 1'b1;
                if (count_q != 5'd0) pop = 1'b1;
            end
            START: begin
                if (tick) begin
                    state_d = DATA;
                    timer_d = TMAX;
                    bit_d   = 2'd0;
                    txd_d   = shift_q[0];
                end
            end
            DATA: begin
                if (tick) begin
                    timer_d = TMAX;
                    if (bit_q == 2'd3) begin
`ifdef OUT_SER_PARITY_EN
                        state_d = PARITY;
                        txd_d   = par_q;
`else
                        state_d = STOP;
                        txd_d   = 1'b1;
`endif
                    end else begin
                        shift_d = {1'b0, shift_q[3:1]};
                        bit_d   = bit_q + 2'd1;
                        txd_d   = shift_q[1];
                    end
                end
            end
`ifdef OUT_SER_PARITY_EN
            PARITY: begin
                if (tick) begin
                    state_d = STOP;
                    timer_d = TMAX;
                    txd_d   = 1'b1;
                end
            end
`endif
            STOP: begin
                if (tick) begin
                    if (count_q != 5'd0) begin
                        pop = 1'b1;
                    end else begin
                        state_d = IDLE;
                        txd_d   = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Loading the head is shared by IDLE and the back-to-back path out of STOP.
        if (pop) begin
            state_d = START;
            timer_d = TMAX;
            shift_d = mem[rd_ptr];
            txd_d   = 1'b0;
`ifdef OUT_SER_PARITY_EN
            par_d   = ^mem[rd_ptr];
`endif
        end
    end

    always_ff @(posedge CK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= IDLE;
            timer_q <= 8'd0;
            bit_q   <= 2'd0;
            shift_q <= 4'd0;
            txd_q   <= 1'b1;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= 5'd0;
            ovf_q   <= 1'b0;
`ifdef OUT_SER_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            txd_q   <= txd_d;
`ifdef OUT_SER_PARITY_EN
            par_q   <= par_d;
`endif
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            if (push && !pop)      count_q <= count_q + 5'd1;
            else if (pop && !push) count_q <= count_q - 5'd1;
            if (LD_OUT && !push) ovf_q <= 1'b1;
        end
    end

    always_ff @(posedge CK) begin
        if (push) mem[wr_ptr] <= BUS;
    end

    assign TXD   = txd_q;
    assign BUSY  = (state_q != IDLE);
    assign FULL  = full;
    assign COUNT = count_q;
    assign OVF   = ovf_q;
endmodule

// File: tb/tb_out_port_serializer.sv
// Bench for out_port_serializer: directed pushes queue expected values; a frame monitor decodes TXD
// cycle by cycle and compares each frame against the queue head.
`timescale 1ns/1ps
module tb_out_port_serializer;
    localparam int DEPTH = 4;
    localparam int B     = 4;
`ifdef OUT_SER_PARITY_EN
    localparam int NB = 7;
`else
    localparam int NB = 6;
`endif

    logic       CK = 1'b0;
    logic       RST_N = 1'b0;
    logic       LD_OUT = 1'b0;
    logic [3:0] BUS = 4'h0;
    logic       TXD, BUSY, FULL, OVF;
    logic [4:0] COUNT;

    int n_pass = 0;
    int n_total = 0;
    int cyc = 0;
    logic [3:0] exp_q[$];
    int start_q[$];

    out_port_serializer #(.DEPTH(DEPTH), .BAUD_DIV(B)) dut (
        .CK(CK), .RST_N(RST_N), .LD_OUT(LD_OUT), .BUS(BUS),
        .TXD(TXD), .BUSY(BUSY), .FULL(FULL), .COUNT(COUNT), .OVF(OVF)
    );

    always #5 CK = ~CK;
    always @(posedge CK) cyc <= cyc + 1;

    task automatic check_eq(input string name, input int act, input int expv);
        n_total++;
        if (act == expv) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, expv);
    endtask

    task automatic push(input logic [3:0] v, input bit accept);
        @(negedge CK);
        LD_OUT = 1'b1;
        BUS    = v;
        @(posedge CK);
        #1;
        LD_OUT = 1'b0;
        if (accept) exp_q.push_back(v);
    endtask

    task automatic wait_drain(input string name, input int budget);
        int n;
        n = 0;
        while ((BUSY !== 1'b0 || COUNT !== 5'd0 || exp_q.size() != 0) && n < budget) begin
            @(negedge CK);
            n++;
        end
        check_eq({name, "_drained_in_budget"}, (n < budget) ? 1 : 0, 1);
    endtask

    // Frame monitor: expected bits are start, data LSB-first, optional even parity, stop.
    initial begin : monitor
        logic [3:0]    d;
        logic [NB-1:0] bits;
        int            bad, first_bad;
        bit            aborted;
        forever begin
            @(negedge CK);
            if (RST_N === 1'b1 && TXD === 1'b0) begin
                start_q.push_back(cyc);
                if (exp_q.size() == 0) begin
                    n_total++;
                    $display("FAIL unexpected_frame: frame started at cycle %0d, expected none", cyc);
                    repeat (NB * B - 1) @(negedge CK);
                end else begin
                    d = exp_q.pop_front();
`ifdef OUT_SER_PARITY_EN
                    bits = {1'b1, ^d, d, 1'b0};
`else
                    bits = {1'b1, d, 1'b0};
`endif
                    bad = 0;
                    first_bad = -1;
                    aborted = 1'b0;
                    for (int c = 0; c < NB * B; c++) begin
                        if (c > 0) @(negedge CK);
                        if (RST_N !== 1'b1) begin
                            aborted = 1'b1;
                            break;
                        end
                        if (TXD !== bits[c / B] || BUSY !== 1'b1) begin
                            bad++;
                            if (first_bad < 0) first_bad = c;
                        end
                    end
                    if (!aborted)
                        check_eq($sformatf("frame_%h_bad_cycles(first_at_%0d)", d, first_bad), bad, 0);
                end
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int bad;
        int gap_bad;

        // Reset state, checked while reset is still asserted.
        RST_N = 1'b0;
        #12;
        check_eq("rst_txd",   TXD,   1);
        check_eq("rst_busy",  BUSY,  0);
        check_eq("rst_count", COUNT, 0);
        check_eq("rst_full",  FULL,  0);
        check_eq("rst_ovf",   OVF,   0);
        @(negedge CK);
        RST_N = 1'b1;

        bad = 0;
        repeat (20) begin
            @(negedge CK);
            if (TXD !== 1'b1 || BUSY !== 1'b0 || COUNT !== 5'd0 || OVF !== 1'b0) bad++;
        end
        check_eq("idle_quiet_bad_cycles", bad, 0);

        // Single push: exact pop edge and exact frame length.
        push(4'hA, 1'b1);
        check_eq("single_count_after_push", COUNT, 1);
        check_eq("single_busy_after_push", BUSY, 0);
        @(posedge CK); #1;
        check_eq("single_txd_start", TXD, 0);
        check_eq("single_busy_start", BUSY, 1);
        check_eq("single_count_after_pop", COUNT, 0);
        repeat (NB * B - 1) @(posedge CK);
        #1;
        check_eq("single_busy_last_stop_cycle", BUSY, 1);
        @(posedge CK); #1;
        check_eq("single_busy_after_frame", BUSY, 0);
        check_eq("single_txd_after_frame", TXD, 1);

        push(4'h7, 1'b1);
        wait_drain("parity_one", 4 * NB * B);

        // Six consecutive pushes into a 4-deep FIFO: 6 is dropped, frames back-to-back.
        start_q.delete();
        push(4'h1, 1'b1);
        check_eq("burst_count_e1", COUNT, 1);
        check_eq("burst_busy_e1", BUSY, 0);
        push(4'h2, 1'b1);
        check_eq("burst_count_e2", COUNT, 1);
        check_eq("burst_busy_e2", BUSY, 1);
        push(4'h3, 1'b1);
        push(4'h4, 1'b1);
        push(4'h5, 1'b1);
        check_eq("burst_full_e5", FULL, 1);
        check_eq("burst_ovf_e5", OVF, 0);
        push(4'h6, 1'b0);
        check_eq("burst_count_e6", COUNT, 4);
        check_eq("burst_full_e6", FULL, 1);
        check_eq("burst_ovf_e6", OVF, 1);
        wait_drain("burst", 8 * NB * B);
        check_eq("burst_frame_count", start_q.size(), 5);
        gap_bad = 0;
        for (int i = 1; i < start_q.size(); i++)
            if (start_q[i] - start_q[i-1] != NB * B) gap_bad++;
        check_eq("burst_gap_bad", gap_bad, 0);
        check_eq("burst_ovf_sticky", OVF, 1);

        // Push while FULL on the exact edge of a pop.
        @(negedge CK); RST_N = 1'b0;
        exp_q.delete();
        @(negedge CK);
        check_eq("ovf_cleared_by_reset", OVF, 0);
        RST_N = 1'b1;
        push(4'h9, 1'b1);
        push(4'h3, 1'b1);
        push(4'hC, 1'b1);
        push(4'h5, 1'b1);
        push(4'hE, 1'b1);
        repeat (NB * B - 4) @(posedge CK);
        #1;
        check_eq("edge_count_before_pop", COUNT, 4);
        push(4'h7, 1'b1);
        check_eq("edge_count_after", COUNT, 4);
        check_eq("edge_full_after", FULL, 1);
        check_eq("edge_ovf_after", OVF, 0);
        wait_drain("edge", 8 * NB * B);
        check_eq("edge_ovf_end", OVF, 0);

        // Reset in the middle of the data bits.
        push(4'hB, 1'b1);
        repeat (10) @(posedge CK);
        #2;
        check_eq("midrst_busy_before", BUSY, 1);
        #1;
        RST_N = 1'b0;
        #1;
        check_eq("midrst_txd", TXD, 1);
        check_eq("midrst_busy", BUSY, 0);
        check_eq("midrst_count", COUNT, 0);
        exp_q.delete();
        repeat (2) @(negedge CK);
        RST_N = 1'b1;
        bad = 0;
        repeat (40) begin
            @(negedge CK);
            if (TXD !== 1'b1 || BUSY !== 1'b0 || COUNT !== 5'd0) bad++;
        end
        check_eq("midrst_no_residual_bad_cycles", bad, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
